// File: rtl/smi_pkg.sv
// smi_pkg: types and default timing shared by the SMI initiator and responder.
package smi_pkg;

    localparam int SMI_DW     = 8;
    localparam int SMI_AW     = 6;
    localparam int SMI_SETUP  = 2;
    localparam int SMI_STROBE = 3;
    localparam int SMI_HOLD   = 1;
    localparam int SMI_PACE   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_PACE
    } smi_state_e;

    function automatic int smi_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/smi_master.sv
// smi_master: SMI bus initiator issuing one timed OE/WE strobe cycle per accepted command.
// Every bus-facing output is a flop, so strobes are glitch-free and release on async reset.
module smi_master
    import smi_pkg::*;
#(
    parameter int DW     = SMI_DW,
    parameter int AW     = SMI_AW,
    parameter int SETUP  = SMI_SETUP,
    parameter int STROBE = SMI_STROBE,
    parameter int HOLD   = SMI_HOLD,
    parameter int PACE   = SMI_PACE
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          busy,
    output logic          smi_oe_n,
    output logic          smi_we_n,
    output logic [AW-1:0] smi_addr,
    output logic [DW-1:0] smi_dout,
    output logic          smi_doe,
    input  logic [DW-1:0] smi_din
);

    localparam int MAXP = smi_max4(SETUP, STROBE, HOLD, PACE);
    localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

    localparam logic [CW-1:0] LD_SETUP  = CW'(SETUP - 1);
    localparam logic [CW-1:0] LD_STROBE = CW'(STROBE - 1);
    localparam logic [CW-1:0] LD_HOLD   = CW'(HOLD - 1);
    localparam logic [CW-1:0] LD_PACE   = CW'((PACE > 0) ? PACE - 1 : 0);

    smi_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          write_q;
    logic          ready_q;
    logic          oe_n_q;
    logic          we_n_q;
    logic          doe_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] dout_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rdata_q;

    logic cnt_done;
    assign cnt_done = (cnt_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            ready_q     <= 1'b0;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            doe_q       <= 1'b0;
            addr_q      <= '0;
            dout_q      <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && ready_q) begin
                        state_q <= ST_SETUP;
                        cnt_q   <= LD_SETUP;
                        ready_q <= 1'b0;
                        write_q <= cmd_write;
                        addr_q  <= cmd_addr;
                        doe_q   <= cmd_write;
                        if (cmd_write) dout_q <= cmd_wdata;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt_done) begin
                        state_q <= ST_STROBE;
                        cnt_q   <= LD_STROBE;
                        we_n_q  <= !write_q;
                        oe_n_q  <= write_q;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_STROBE: begin
                    if (cnt_done) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= LD_HOLD;
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        // Read data is taken on the edge that closes the strobe.
                        if (!write_q) begin
                            rsp_valid_q <= 1'b1;
                            rdata_q     <= smi_din;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_done) begin
                        doe_q <= 1'b0;
                        if (PACE > 0) begin
                            state_q <= ST_PACE;
                            cnt_q   <= LD_PACE;
                        end else begin
                            state_q <= ST_IDLE;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_PACE: begin
                    if (cnt_done) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign smi_oe_n  = oe_n_q;
    assign smi_we_n  = we_n_q;
    assign smi_doe   = doe_q;
    assign smi_addr  = addr_q;
    assign smi_dout  = dout_q;

endmodule

// File: tb/tb_smi_master.sv
// tb_smi_master: scoreboard bench for smi_master across three timing configurations.
module tb_smi_master;

    localparam int S_P [3] = '{2, 2, 1};
    localparam int T_P [3] = '{3, 3, 1};
    localparam int H_P [3] = '{1, 1, 1};
    localparam int P_P [3] = '{0, 2, 0};

    logic       clk;
    logic       reset_n;
    logic       cmd_valid [3];
    logic       cmd_ready [3];
    logic       cmd_write [3];
    logic [5:0] cmd_addr  [3];
    logic [7:0] cmd_wdata [3];
    logic       rsp_valid [3];
    logic [7:0] rsp_rdata [3];
    logic       busy      [3];
    logic       smi_oe_n  [3];
    logic       smi_we_n  [3];
    logic [5:0] smi_addr  [3];
    logic [7:0] smi_dout  [3];
    logic       smi_doe   [3];
    logic [7:0] smi_din   [3];

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    logic [7:0] sb [$];
    logic [7:0] last_rd [3];

    smi_master #(.SETUP(2), .STROBE(3), .HOLD(1), .PACE(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_write(cmd_write[0]), .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
        .smi_oe_n(smi_oe_n[0]), .smi_we_n(smi_we_n[0]), .smi_addr(smi_addr[0]),
        .smi_dout(smi_dout[0]), .smi_doe(smi_doe[0]), .smi_din(smi_din[0])
    );

    smi_master #(.SETUP(2), .STROBE(3), .HOLD(1), .PACE(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_write(cmd_write[1]), .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
        .smi_oe_n(smi_oe_n[1]), .smi_we_n(smi_we_n[1]), .smi_addr(smi_addr[1]),
        .smi_dout(smi_dout[1]), .smi_doe(smi_doe[1]), .smi_din(smi_din[1])
    );

    smi_master #(.SETUP(1), .STROBE(1), .HOLD(1), .PACE(0)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
        .cmd_write(cmd_write[2]), .cmd_addr(cmd_addr[2]), .cmd_wdata(cmd_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .busy(busy[2]),
        .smi_oe_n(smi_oe_n[2]), .smi_we_n(smi_we_n[2]), .smi_addr(smi_addr[2]),
        .smi_dout(smi_dout[2]), .smi_doe(smi_doe[2]), .smi_din(smi_din[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ctl(input int k);
        return {busy[k], cmd_ready[k], rsp_valid[k], smi_doe[k], smi_we_n[k], smi_oe_n[k]};
    endfunction

    // Caller sits at a negedge; the command is offered in that same cycle.
    task automatic do_cmd(input int k, input bit w, input logic [5:0] a, input logic [7:0] wd,
                          input logic [7:0] rd, input bit hold_valid, output int hs);
        int s;
        int t;
        int h;
        int p;
        int n;
        logic [5:0] exp_v;
        s = S_P[k];
        t = T_P[k];
        h = H_P[k];
        p = P_P[k];
        n = 0;
        hs = -1;
        cmd_valid[k] = 1'b1;
        cmd_write[k] = w;
        cmd_addr[k]  = a;
        cmd_wdata[k] = wd;
        smi_din[k]   = ~rd;
        while (!cmd_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready[k]) begin
            chk($sformatf("k%0d handshake timeout", k), 32'd0, 32'd1);
            cmd_valid[k] = 1'b0;
            return;
        end
        hs = cyc;
        if (!w) sb.push_back(rd);
        for (int c = 1; c <= s + t + h + p + 1; c++) begin
            @(negedge clk);
            if (!hold_valid) cmd_valid[k] = 1'b0;
            exp_v = {c <= s + t + h + p, c == s + t + h + p + 1, !w && c == s + t + 1,
                     w && c <= s + t + h, !(w && c > s && c <= s + t), !(!w && c > s && c <= s + t)};
            chk($sformatf("k%0d c%0d ctl", k, c), ctl(k), exp_v);
            if (c <= s + t + h) chk($sformatf("k%0d c%0d addr", k, c), smi_addr[k], a);
            if (w && c <= s + t + h) chk($sformatf("k%0d c%0d dout", k, c), smi_dout[k], wd);
            if (rsp_valid[k]) begin
                if (sb.size() == 0) chk($sformatf("k%0d unexpected rsp", k), 32'd1, 32'd0);
                else chk($sformatf("k%0d rdata", k), rsp_rdata[k], sb.pop_front());
            end
            smi_din[k] = (!w && c > s && c <= s + t) ? rd : ~rd;
        end
        chk($sformatf("k%0d rdata hold", k), rsp_rdata[k], w ? last_rd[k] : rd);
        if (!w) last_rd[k] = rd;
    endtask

    initial begin
        int h1;
        int h2;
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cmd_valid[k] = 1'b0;
            cmd_write[k] = 1'b0;
            cmd_addr[k]  = '0;
            cmd_wdata[k] = '0;
            smi_din[k]   = '0;
            last_rd[k]   = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("k%0d reset ctl", k), ctl(k), 6'b000011);
            chk($sformatf("k%0d reset addr", k), smi_addr[k], 6'h0);
            chk($sformatf("k%0d reset dout", k), smi_dout[k], 8'h0);
            chk($sformatf("k%0d reset rdata", k), rsp_rdata[k], 8'h0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("k%0d ready after reset", k), ctl(k), 6'b010011);

        do_cmd(0, 1'b1, 6'h03, 8'h45, 8'h00, 1'b0, h1);
        do_cmd(0, 1'b0, 6'h11, 8'h00, 8'h65, 1'b0, h1);

        do_cmd(0, 1'b0, 6'h05, 8'h00, 8'h3C, 1'b1, h1);
        do_cmd(0, 1'b1, 6'h06, 8'hA5, 8'h00, 1'b0, h2);
        chk("k0 back-to-back spacing", h2 - h1, 32'd7);

        for (int i = 0; i < 4; i++) do_cmd(0, 1'b0, 6'(i), 8'h00, i[0] ? 8'h65 : 8'h45, i < 3, h1);

        do_cmd(1, 1'b0, 6'h21, 8'h00, 8'h5A, 1'b1, h1);
        do_cmd(1, 1'b1, 6'h22, 8'hC3, 8'h00, 1'b0, h2);
        chk("k1 pace spacing", h2 - h1, 32'd9);

        do_cmd(2, 1'b0, 6'h3F, 8'h00, 8'h81, 1'b1, h1);
        do_cmd(2, 1'b1, 6'h30, 8'h7E, 8'h00, 1'b0, h2);
        chk("k2 min-timing spacing", h2 - h1, 32'd4);

        cmd_valid[0] = 1'b1;
        cmd_write[0] = 1'b1;
        cmd_addr[0]  = 6'h2A;
        cmd_wdata[0] = 8'h5A;
        chk("k0 abort handshake ready", cmd_ready[0], 1'b1);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("k0 abort pre-reset we/doe", {smi_we_n[0], smi_doe[0]}, 2'b01);
        #2 reset_n = 1'b0;
        #1 chk("k0 async abort", {smi_we_n[0], smi_oe_n[0], smi_doe[0], busy[0], cmd_ready[0]}, 5'b11000);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) last_rd[k] = '0;
        repeat (6) begin
            @(negedge clk);
            chk("k0 no rsp after abort", rsp_valid[0], 1'b0);
        end
        chk("k0 idle after abort", ctl(0), 6'b010011);
        chk("scoreboard drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/smi_master.md
Name: smi_master

Overview:
- Initiator end of the Pi SMI parallel bus: generates OE/WE strobe cycles with programmable setup/strobe/hold/pace timing.
- Stands in for the Pi's SMI controller:
  - in simulation, to exercise the FPGA-side smi responder;
  - on a second FPGA target that drives an SMI peripheral.
- Accepts one read or write command at a time through a valid/ready interface and returns read data through a one-cycle response pulse.

Parameters:
- DW, 8, data bus width.
- AW, 6, SMI address width (SA lines).
- SETUP, 2, cycles address/data are valid before the strobe asserts (min 1).
- STROBE, 3, cycles the strobe is held low (min 1).
- HOLD, 1, cycles address/data are held after the strobe deasserts (min 1).
- PACE, 0, idle cycles forced between consecutive bus cycles (min 0).

Ports:
- clk  in  1  system clock (64 MHz PLL output).
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  bus address.
- cmd_wdata  in  DW  write data.
- rsp_valid  out  1  one-cycle pulse carrying read data.
- rsp_rdata  out  DW  read data captured from the bus.
- busy  out  1  bus cycle in progress (not IDLE).
- smi_oe_n  out  1  read strobe, active low.
- smi_we_n  out  1  write strobe, active low.
- smi_addr  out  AW  address lines.
- smi_dout  out  DW  data driven onto the bus.
- smi_doe  out  1  data output enable; the top level builds the tristate pads from this.
- smi_din  in  DW  data sampled from the bus.

Behaviour:
- Reset values (asynchronous, any state):
  - smi_oe_n=1, smi_we_n=1, smi_doe=0.
  - smi_addr=0, smi_dout=0.
  - rsp_valid=0, rsp_rdata=0.
  - busy=0, cmd_ready=0 while reset_n low; state=IDLE.
  - Reset mid-cycle aborts the transfer immediately: strobes release and the bus tristates with no clock edge required. No response is issued for the aborted command.
- States: IDLE, SETUP, STROBE, HOLD, PACE. A single down-counter, wide enough for max(SETUP,STROBE,HOLD,PACE), times each phase.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch write flag, addr and wdata, then go to SETUP (counter=SETUP-1).
  - No combinational path from cmd_valid to cmd_ready.
- SETUP:
  - smi_addr=latched addr.
  - On a write, smi_doe=1 and smi_dout=wdata.
  - Strobes remain high.
  - After SETUP cycles, go to STROBE.
- STROBE:
  - Write: smi_we_n=0. Read: smi_oe_n=0 and smi_doe=0.
  - Lasts STROBE cycles.
  - On a read, smi_din is registered into rsp_rdata on the clock edge that ends the last STROBE cycle.
- HOLD:
  - Strobes high; addr and write data stay driven.
  - On a read, rsp_valid=1 during the first HOLD cycle only.
  - After HOLD cycles, go to PACE if PACE>0, else IDLE.
- PACE: bus idle (smi_doe=0, strobes high) for PACE cycles, then IDLE.
- Outputs:
  - All bus outputs come straight from flops; no glitches on the strobes.
  - OE and WE are never low in the same cycle.
  - smi_doe=0 whenever smi_oe_n=0.
- Timing:
  - Total bus cycle = SETUP+STROBE+HOLD cycles.
  - Command-to-command throughput = 1+SETUP+STROBE+HOLD+PACE cycles.
- Boundary and ordering rules:
  - cmd inputs are ignored outside IDLE; the upstream holds them until ready.
  - rsp_rdata holds its value until the next read.
  - Writes produce no rsp_valid.
  - smi_addr keeps its last value when idle.

Decomposition:
- Package smi_pkg:
  - state enum (IDLE/SETUP/STROBE/HOLD/PACE);
  - default timing constants;
  - DW/AW defaults shared with the smi responder.
- No sub-module. The phase counter is inline; a timing counter is too small to justify a separate module.

Test Plan (default parameters, cycle 0 = handshake cycle):
- Write 0x45 to addr 0x03:
  - smi_doe=1 and smi_dout=0x45 in cycles 1–6.
  - smi_we_n=0 in cycles 3–5.
  - cmd_ready=1 again in cycle 7.
  - smi_oe_n stays 1 throughout; no rsp_valid.
- Read with smi_din=0x65 during the strobe:
  - smi_oe_n=0 in cycles 3–5, smi_doe=0 throughout.
  - rsp_valid=1 in cycle 6 only, with rsp_rdata=0x65.
- Back-to-back: read then write with cmd_valid held high:
  - second handshake in cycle 7;
  - second strobe in cycles 10–12.
  - With PACE=2, second handshake in cycle 9.
- Reset asserted during cycle 4 of a write:
  - smi_we_n goes 1 and smi_doe goes 0 asynchronously, before the next edge.
  - After release, state=IDLE and no rsp_valid.
- Loopback against the smi responder, which toggles case on each read:
  - 4 reads return 0x45, 0x65, 0x45, 0x65.
- SETUP=STROBE=HOLD=1:
  - read strobe low exactly 1 cycle;
  - throughput of 4 cycles per command.
